axi_burst_tester: RTL

Synthesizable, self-checking AXI4 master traffic generator that supersedes the hand-written write task used on the `axi_ram` bench. On a `start` pulse it issues one parametrised write burst (FIXED/INCR/WRAP, 1–256 beats) with a seed-derived data pattern, waits for the write response, reads the same burst back, and reports the number of mismatches and protocol errors. It connects to any `axi_if` slave, in hardware or simulation, as a reusable memory and interconnect checker.

---
 rtl/axi_if.sv | 69 ++++++
 rtl/axi_burst_tester.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/axi_if.sv
// rtl/axi_if.sv - AXI4 bus bundle with master and slave views
interface axi_if #(
    parameter int ID_W_WIDTH = 4,
    parameter int ID_R_WIDTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ID_W_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_W_WIDTH-1:0]   bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_R_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [ID_R_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport m (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport s (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_burst_tester.sv
// rtl/axi_burst_tester.sv - AXI4 write-then-readback burst checker with error count
module axi_burst_tester #(
    parameter int ID_W_WIDTH = 4,
    parameter int ID_R_WIDTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TXN_ID     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt,
    axi_if.m                      axi_m
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [2:0]            AX_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [ID_W_WIDTH-1:0] W_ID    = ID_W_WIDTH'(TXN_ID);
    localparam logic [ID_R_WIDTH-1:0] R_ID    = ID_R_WIDTH'(TXN_ID);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;
    logic [1:0]            cmd_burst;
    logic [DATA_WIDTH-1:0] cmd_seed;
    logic [7:0]            beat;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  cnt_hit;
    logic [2:0]            b_errs;
    logic [2:0]            r_errs;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] n);
        logic [16:0] s;
        s = {1'b0, a} + {14'b0, n};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        illegal   = (burst == 2'd3) ||
                    ((burst == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        beat_data = cmd_seed + DATA_WIDTH'(beat);
        cnt_hit   = (beat == cmd_len);
        b_errs    = {2'b0, axi_m.bresp != 2'b00} + {2'b0, axi_m.bid != W_ID};
        // A last-beat disagreement between RLAST and our own count is one extra error.
        r_errs    = {2'b0, axi_m.rdata != beat_data} + {2'b0, axi_m.rresp != 2'b00} +
                    {2'b0, axi_m.rid != R_ID} + {2'b0, axi_m.rlast != cnt_hit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            cmd_burst <= '0;
            cmd_seed  <= '0;
            beat      <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cmd_addr  <= base_addr;
                    cmd_len   <= len;
                    cmd_burst <= burst;
                    cmd_seed  <= seed;
                    beat      <= '0;
                    if (illegal) begin
                        err_cnt <= 16'd1;
                        state   <= S_DONE;
                    end else begin
                        err_cnt <= '0;
                        state   <= S_AW;
                    end
                end
                S_AW: if (axi_m.awready) begin
                    beat  <= '0;
                    state <= S_W;
                end
                S_W: if (axi_m.wready) begin
                    if (cnt_hit) state <= S_B;
                    else         beat  <= beat + 8'd1;
                end
                S_B: if (axi_m.bvalid) begin
                    err_cnt <= sat_add(err_cnt, b_errs);
                    state   <= S_AR;
                end
                S_AR: if (axi_m.arready) begin
                    beat  <= '0;
                    state <= S_R;
                end
                S_R: if (axi_m.rvalid) begin
                    err_cnt <= sat_add(err_cnt, r_errs);
                    if (axi_m.rlast || cnt_hit) state <= S_DONE;
                    else                        beat  <= beat + 8'd1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Payloads are gated by state so every master output reads 0 outside its phase and in reset.
    assign axi_m.awvalid = (state == S_AW);
    assign axi_m.awid    = (state == S_AW) ? W_ID      : '0;
    assign axi_m.awaddr  = (state == S_AW) ? cmd_addr  : '0;
    assign axi_m.awlen   = (state == S_AW) ? cmd_len   : '0;
    assign axi_m.awsize  = (state == S_AW) ? AX_SIZE   : '0;
    assign axi_m.awburst = (state == S_AW) ? cmd_burst : '0;
    assign axi_m.awlock  = 1'b0;
    assign axi_m.awcache = '0;
    assign axi_m.awprot  = '0;

    assign axi_m.wvalid  = (state == S_W);
    assign axi_m.wdata   = (state == S_W) ? beat_data : '0;
    assign axi_m.wstrb   = (state == S_W) ? '1 : '0;
    assign axi_m.wlast   = (state == S_W) && cnt_hit;

    assign axi_m.bready  = (state == S_B);

    assign axi_m.arvalid = (state == S_AR);
    assign axi_m.arid    = (state == S_AR) ? R_ID      : '0;
    assign axi_m.araddr  = (state == S_AR) ? cmd_addr  : '0;
    assign axi_m.arlen   = (state == S_AR) ? cmd_len   : '0;
    assign axi_m.arsize  = (state == S_AR) ? AX_SIZE   : '0;
    assign axi_m.arburst = (state == S_AR) ? cmd_burst : '0;
    assign axi_m.arlock  = 1'b0;
    assign axi_m.arcache = '0;
    assign axi_m.arprot  = '0;

    assign axi_m.rready  = (state == S_R);
endmodule
